// File: rtl/ethpipe_tx_pkg.sv
// ethpipe_tx_pkg: definitions shared by the GMII transmit engine.
//   state_t        - transmit FSM states (IDLE, PRE, DATA, FCS, IFG)
//   PREAMBLE_BYTE  - preamble octet (0x55)
//   SFD_BYTE       - start-of-frame delimiter (0xD5)
//   CRC32_POLY     - IEEE 802.3 generator, normal form
//   CRC32_RESIDUE  - good-frame residue, normal form
//   CRC32_POLY_REFL- generator in the bit order used by the LSB-first datapath
package ethpipe_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_FCS  = 3'd3,
    ST_IFG  = 3'd4
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

endpackage

// File: rtl/ethpipe_crc32_d8.sv
// ethpipe_crc32_d8: one combinational CRC-32 step over a single octet.
// Bits are consumed LSB first (reflected CRC), so the register holds the
// reflected remainder; the caller owns the state register, init and final
// complement.
//   i_crc  [31:0] current remainder
//   i_data [7:0]  octet to absorb
//   o_crc  [31:0] remainder after absorbing i_data
module ethpipe_crc32_d8
  import ethpipe_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = i_crc;
    for (int b = 0; b < 8; b++)
      o_crc = (o_crc >> 1) ^ ((o_crc[0] ^ i_data[b]) ? CRC32_POLY_REFL : 32'h0);
  end

endmodule

// File: rtl/ethpipe_tx.sv
// ethpipe_tx: GMII transmit engine. Sends preamble + SFD, streams a frame
// from the 16-bit TX slot RAM, optionally appends an FCS, holds the
// inter-frame gap and reports completion with a departure timestamp.
// Build option: define ETHPIPE_TX_CRC_EN to generate and append the CRC-32
// FCS; otherwise the host places the FCS inside the frame itself.
// Ports:
//   gmii_tx_clk         clock (sole)
//   sys_rst             synchronous active-high reset
//   global_counter[31:0] timestamp source
//   gmii_txd[7:0], gmii_tx_en   GMII transmit pins
//   slot_tx_eth_address[11:0]   slot RAM word address (registered)
//   slot_tx_eth_q[15:0]         slot RAM data, valid 1 cycle after address
//   tx_frame_len[11:0]          frame length in bytes (no FCS)
//   tx_start                    1-cycle start request
//   tx_busy                     accept .. end of IFG
//   tx_complete                 1-cycle pulse on the first IFG cycle
//   tx_timestamp[31:0]          global_counter during the SFD cycle
module ethpipe_tx
  import ethpipe_tx_pkg::*;
#(
  parameter logic [11:0] FRAME_BASE = 12'd2,
  parameter int          IFG_CYCLES = 12,
  parameter logic [11:0] MAX_LEN    = 12'd1518
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic [31:0] global_counter,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic [11:0] slot_tx_eth_address,
  input  logic [15:0] slot_tx_eth_q,
  input  logic [11:0] tx_frame_len,
  input  logic        tx_start,
  output logic        tx_busy,
  output logic        tx_complete,
  output logic [31:0] tx_timestamp
);

  // The IDLE cycle that launches a queued frame counts as one gap cycle,
  // so the IFG state itself lasts IFG_CYCLES-1 cycles.
  localparam logic [11:0] IFG_LAST = 12'(IFG_CYCLES - 2);

  state_t      r_state;
  logic        r_pend;
  logic        r_tx_en;
  logic        r_busy;
  logic        r_complete;
  logic [7:0]  r_txd;
  logic [11:0] r_addr;
  logic [11:0] r_cnt;   // PRE: cycle index; DATA: byte on txd; FCS: octet; IFG: cycle
  logic [11:0] r_len;
  logic [31:0] r_ts;

  logic [11:0] w_len_clip;
  logic [7:0]  w_byte;
  logic        w_last_byte;

  assign w_len_clip = (tx_frame_len > MAX_LEN) ? MAX_LEN : tx_frame_len;

  // Octet loaded into r_txd at this edge. Leaving PRE loads byte 0 (low half);
  // in DATA the next index is cnt+1, which is even exactly when cnt is odd.
  assign w_byte = (r_state == ST_PRE || r_cnt[0]) ? slot_tx_eth_q[7:0]
                                                  : slot_tx_eth_q[15:8];
  assign w_last_byte = (r_cnt + 12'd1) == r_len;

`ifdef ETHPIPE_TX_CRC_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  ethpipe_crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_next)
  );
`endif

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_pend     <= 1'b0;
      r_tx_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
      r_txd      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_ts       <= '0;
`ifdef ETHPIPE_TX_CRC_EN
      r_crc      <= '0;
`endif
    end else begin
      r_complete <= 1'b0;
      if (tx_start) r_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          // Parked on the first word so it is already on q when PRE ends.
          r_addr <= FRAME_BASE;
          r_busy <= 1'b0;
          if (r_pend || tx_start) begin
            r_pend <= 1'b0;
            r_len  <= w_len_clip;
            if (w_len_clip != 12'd0) begin
              r_state <= ST_PRE;
              r_busy  <= 1'b1;
              r_tx_en <= 1'b1;
              r_txd   <= PREAMBLE_BYTE;
              r_cnt   <= '0;
`ifdef ETHPIPE_TX_CRC_EN
              r_crc   <= '1;
`endif
            end
          end
        end

        ST_PRE: begin
          r_cnt <= r_cnt + 12'd1;
          if (r_cnt == 12'd6) begin
            r_txd <= SFD_BYTE;
          end else if (r_cnt == 12'd7) begin
            // Current cycle carries the SFD.
            r_ts    <= global_counter;
            r_txd   <= w_byte;
            r_cnt   <= '0;
            r_addr  <= r_addr + 12'd1;
            r_state <= ST_DATA;
`ifdef ETHPIPE_TX_CRC_EN
            r_crc   <= w_crc_next;
`endif
          end else begin
            r_txd <= PREAMBLE_BYTE;
          end
        end

        ST_DATA: begin
          if (w_last_byte) begin
            r_cnt <= '0;
`ifdef ETHPIPE_TX_CRC_EN
            r_txd   <= ~r_crc[7:0];
            r_crc   <= r_crc >> 8;
            r_state <= ST_FCS;
`else
            r_tx_en    <= 1'b0;
            r_txd      <= '0;
            r_complete <= 1'b1;
            r_state    <= ST_IFG;
`endif
          end else begin
            r_txd <= w_byte;
            r_cnt <= r_cnt + 12'd1;
            // Word changes after each odd byte: prefetch one cycle ahead.
            if (r_cnt[0]) r_addr <= r_addr + 12'd1;
`ifdef ETHPIPE_TX_CRC_EN
            r_crc <= w_crc_next;
`endif
          end
        end

`ifdef ETHPIPE_TX_CRC_EN
        ST_FCS: begin
          if (r_cnt == 12'd3) begin
            r_tx_en    <= 1'b0;
            r_txd      <= '0;
            r_complete <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_IFG;
          end else begin
            r_txd <= ~r_crc[7:0];
            r_crc <= r_crc >> 8;
            r_cnt <= r_cnt + 12'd1;
          end
        end
`endif

        ST_IFG: begin
          if (r_cnt == IFG_LAST) begin
            r_state <= ST_IDLE;
            // Stay busy across the launch cycle when another frame is queued.
            r_busy  <= r_pend | tx_start;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gmii_txd            = r_txd;
  assign gmii_tx_en          = r_tx_en;
  assign slot_tx_eth_address = r_addr;
  assign tx_busy             = r_busy;
  assign tx_complete         = r_complete;
  assign tx_timestamp        = r_ts;

endmodule
